// File: rtl/cache_request_driver_pkg.sv
// Shared types for the cache request driver: FSM states, request table entry
// layout and operation codes.
package cache_tb_pkg;

  // Table entries are stored at these widths; the driver uses the low bits.
  localparam int ADDR_MAX_W = 32;
  localparam int DATA_MAX_W = 64;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE,
    ERR
  } state_e;

  typedef struct packed {
    logic                  rw;
    logic                  lb;
    logic                  chk;
    logic [ADDR_MAX_W-1:0] addr;
    logic [DATA_MAX_W-1:0] wdata;
    logic [DATA_MAX_W-1:0] exp;
  } req_entry_t;

endpackage

// File: rtl/cache_request_driver_if.sv
// CPU-side request/response bus between the request driver (master) and the
// cache under test (slave).
interface cache_request_driver_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              read_write;
  logic              if_lb;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic              hit_miss;
  logic [DATA_W-1:0] Read_Data;

  modport master (
    output read_write, if_lb, address, write_data,
    input  hit_miss, Read_Data
  );

  modport slave (
    input  read_write, if_lb, address, write_data,
    output hit_miss, Read_Data
  );
endinterface

// File: rtl/cache_request_driver_req_table.sv
// Request table: DEPTH entries, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module req_table
  import cache_tb_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  req_entry_t       wentry_i,
  input  logic [IDX_W-1:0] ridx_i,
  output req_entry_t       rentry_o
);

  req_entry_t rd_vec [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      req_entry_t ent_q;

      always_ff @(posedge clock) begin
        if (we_i && (widx_i == IDX_W'(gi))) begin
          ent_q <= wentry_i;
        end
      end

      assign rd_vec[gi] = ent_q;
    end
  endgenerate

  assign rentry_o = rd_vec[ridx_i];

endmodule

// File: rtl/cache_request_driver.sv
// Replays a programmed table of cache load/store requests, advancing on hits,
// checking read data and flagging a hang when no hit arrives in time.
module cache_request_driver
  import cache_tb_pkg::*;
#(
  parameter int  ADDR_W  = 10,
  parameter int  DATA_W  = 32,
  parameter int  DEPTH   = 16,
  parameter int  TIMEOUT = 64,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int TMR_W   = $clog2(TIMEOUT + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  prog_we,
  input  logic [IDX_W-1:0]      prog_idx,
  input  logic                  prog_rw,
  input  logic                  prog_lb,
  input  logic                  prog_chk,
  input  logic [ADDR_W-1:0]     prog_addr,
  input  logic [DATA_W-1:0]     prog_wdata,
  input  logic [DATA_W-1:0]     prog_exp,
  input  logic [CNT_W-1:0]      prog_len,
  input  logic                  start,
  cache_request_driver_if.master cache_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [IDX_W-1:0]      fail_idx
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  req_entry_t       cur_entry;
  req_entry_t       wr_entry;
  logic             tbl_we;
  logic [CNT_W-1:0] run_len;
  logic             last_req;
  logic             rd_match;
  logic             unused_entry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // The table is frozen while a run is in flight.
  assign tbl_we = prog_we && (state_q != ISSUE);

  always_comb begin
    wr_entry       = '0;
    wr_entry.rw    = prog_rw;
    wr_entry.lb    = prog_lb;
    wr_entry.chk   = prog_chk;
    wr_entry.addr  = ADDR_MAX_W'(prog_addr);
    wr_entry.wdata = DATA_MAX_W'(prog_wdata);
    wr_entry.exp   = DATA_MAX_W'(prog_exp);
  end

  req_table #(
    .DEPTH (DEPTH)
  ) u_table (
    .clock    (clock),
    .we_i     (tbl_we),
    .widx_i   (prog_idx),
    .wentry_i (wr_entry),
    .ridx_i   (idx_q),
    .rentry_o (cur_entry)
  );

  // Upper bits of the stored fields are zero-extension only.
  assign unused_entry = ^cur_entry;

  assign run_len  = (prog_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : prog_len;
  assign last_req = (CNT_W'(idx_q) == (len_q - CNT_W'(1)));
  assign rd_match = (cur_entry.exp[DATA_W-1:0] == cache_bus.Read_Data);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      fail_idx_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      timer_q    <= timer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    timer_d    = timer_q;

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          len_d      = run_len;
          idx_d      = '0;
          pass_d     = '0;
          fail_d     = '0;
          fail_idx_d = '0;
          timer_d    = '0;
          state_d    = (run_len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (cache_bus.hit_miss) begin
          if ((cur_entry.rw == OP_READ) && cur_entry.chk && !rd_match) begin
            fail_d = sat_inc(fail_q);
            if (fail_q == '0) begin
              fail_idx_d = idx_q;
            end
          end else begin
            pass_d = sat_inc(pass_q);
          end
          timer_d = '0;
          if (last_req) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // After a timeout the request stays visible so the hung entry can be seen.
  always_comb begin
    cache_bus.read_write = 1'b0;
    cache_bus.if_lb      = 1'b0;
    cache_bus.address    = '0;
    cache_bus.write_data = '0;
    if ((state_q == ISSUE) || (state_q == ERR)) begin
      cache_bus.read_write = cur_entry.rw;
      cache_bus.if_lb      = cur_entry.lb;
      cache_bus.address    = cur_entry.addr[ADDR_W-1:0];
      cache_bus.write_data = cur_entry.wdata[DATA_W-1:0];
    end
  end

  assign busy        = (state_q == ISSUE);
  assign done        = (state_q == DONE);
  assign timeout_err = (state_q == ERR);
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign fail_idx    = fail_idx_q;

endmodule
